// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU command sequencer:
//   - cmd_op encodings (AND/OR/ADD/SUB)
//   - ALU Operation encodings (AND=00, OR=01, ADD=10)
//   - sequencer state encoding
//   - ALU control decode and response flag helper functions
// Optional feature macro used by the sequencer: ALU_SEQ_WIDE_EN.
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } cmd_op_t;

   localparam logic [1:0] ALU_OP_AND = 2'b00;
   localparam logic [1:0] ALU_OP_OR  = 2'b01;
   localparam logic [1:0] ALU_OP_ADD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_EXEC    = 2'b01,
      ST_EXEC_HI = 2'b10,
      ST_RESP    = 2'b11
   } state_t;

   typedef struct packed {
      logic [1:0] operation;
      logic       binvert;
      logic       carryin;
   } alu_ctrl_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic ovf;
   } flags_t;

   function automatic logic is_arith(input cmd_op_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // ALU control for the low (first) pass. SUB is a + ~b + 1.
   function automatic alu_ctrl_t alu_ctrl(input cmd_op_t op);
      alu_ctrl_t c;
      c.operation = ALU_OP_AND;
      c.binvert   = 1'b0;
      c.carryin   = 1'b0;
      case (op)
         OP_AND:  c.operation = ALU_OP_AND;
         OP_OR:   c.operation = ALU_OP_OR;
         OP_ADD:  c.operation = ALU_OP_ADD;
         OP_SUB: begin
            c.operation = ALU_OP_ADD;
            c.binvert   = 1'b1;
            c.carryin   = 1'b1;
         end
         default: c.operation = ALU_OP_AND;
      endcase
      return c;
   endfunction

   // Flags of the final pass. b_msb is the raw operand bit; the ALU applies
   // Binvert internally, so the effective operand sign is recovered here.
   // lower_zero carries the zero-ness of the low word into a wide result.
   function automatic flags_t calc_flags(input cmd_op_t          op,
                                         input logic             a_msb,
                                         input logic             b_msb,
                                         input logic [DATA_W-1:0] res,
                                         input logic             cout,
                                         input logic             lower_zero);
      flags_t f;
      logic   beff_msb;
      beff_msb = (op == OP_SUB) ? ~b_msb : b_msb;
      f.zero   = lower_zero && (res == '0);
      f.carry  = is_arith(op) && cout;
      f.ovf    = is_arith(op) && (a_msb == beff_msb) && (res[DATA_W-1] != a_msb);
      return f;
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Command-side controller for an external 32-bit combinational ALU
// (AND/OR/ADD with Binvert and Carryin). Accepts one command at a time over
// a valid/ready handshake, drives the ALU for one pass (two passes for a
// 64-bit command), and holds a registered response with zero/carry/overflow
// flags until the consumer accepts it.
//
// Optional feature: define ALU_SEQ_WIDE_EN to add the 64-bit (two pass)
// operations and the cmd_wide / cmd_a_hi / cmd_b_hi / rsp_result_hi ports.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b       00 AND, 01 OR, 10 ADD, 11 SUB; low operands
//   cmd_wide, cmd_a_hi/_b_hi   64-bit request and high operands (wide build)
//   alu_a, alu_b, alu_binvert,
//   alu_carryin, alu_operation registered ALU drive, 0 outside EXEC/EXEC_HI
//   alu_result, alu_carryout   ALU outputs, sampled at the end of each pass
//   rsp_valid / rsp_ready      response handshake
//   rsp_result, rsp_result_hi  result words (high word in wide build only)
//   rsp_zero/_carry/_ovf       flags of the final pass
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
`ifdef ALU_SEQ_WIDE_EN
   input  logic        cmd_wide,
   input  logic [31:0] cmd_a_hi,
   input  logic [31:0] cmd_b_hi,
   output logic [31:0] rsp_result_hi,
`endif
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_binvert,
   output logic        alu_carryin,
   output logic [1:0]  alu_operation,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_carry,
   output logic        rsp_ovf
);

   state_t    state;
   cmd_op_t   op_p0;
   flags_t    flags_p1;
   alu_ctrl_t cmd_ctrl;

`ifdef ALU_SEQ_WIDE_EN
   logic        wide_p0;
   logic [31:0] a_hi_p0;
   logic [31:0] b_hi_p0;
`endif

   assign cmd_ctrl  = alu_ctrl(cmd_op_t'(cmd_op));
   assign rsp_zero  = flags_p1.zero;
   assign rsp_carry = flags_p1.carry;
   assign rsp_ovf   = flags_p1.ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         op_p0         <= OP_AND;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_binvert   <= 1'b0;
         alu_carryin   <= 1'b0;
         alu_operation <= ALU_OP_AND;
         rsp_result    <= '0;
         flags_p1      <= '0;
`ifdef ALU_SEQ_WIDE_EN
         wide_p0       <= 1'b0;
         a_hi_p0       <= '0;
         b_hi_p0       <= '0;
         rsp_result_hi <= '0;
`endif
      end else begin
         case (state)
            // ---- accept: latch command, preload ALU drive for the low pass
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_p0         <= cmd_op_t'(cmd_op);
                  alu_a         <= cmd_a;
                  alu_b         <= cmd_b;
                  alu_operation <= cmd_ctrl.operation;
                  alu_binvert   <= cmd_ctrl.binvert;
                  alu_carryin   <= cmd_ctrl.carryin;
                  cmd_ready     <= 1'b0;
                  state         <= ST_EXEC;
`ifdef ALU_SEQ_WIDE_EN
                  wide_p0       <= cmd_wide;
                  a_hi_p0       <= cmd_a_hi;
                  b_hi_p0       <= cmd_b_hi;
`endif
               end
            end

            // ---- low pass: capture result, finish or chain to the high pass
            ST_EXEC: begin
               rsp_result    <= alu_result;
               flags_p1      <= calc_flags(op_p0, alu_a[31], alu_b[31],
                                           alu_result, alu_carryout, 1'b1);
               alu_a         <= '0;
               alu_b         <= '0;
               alu_binvert   <= 1'b0;
               alu_carryin   <= 1'b0;
               alu_operation <= ALU_OP_AND;
               rsp_valid     <= 1'b1;
               state         <= ST_RESP;
`ifdef ALU_SEQ_WIDE_EN
               rsp_result_hi <= '0;
               // A wide command overrides the narrow completion above: keep
               // Operation/Binvert, switch to the high words, chain the carry.
               if (wide_p0) begin
                  alu_a         <= a_hi_p0;
                  alu_b         <= b_hi_p0;
                  alu_binvert   <= alu_binvert;
                  alu_operation <= alu_operation;
                  alu_carryin   <= is_arith(op_p0) && alu_carryout;
                  rsp_valid     <= 1'b0;
                  state         <= ST_EXEC_HI;
               end
`endif
            end

`ifdef ALU_SEQ_WIDE_EN
            // ---- high pass: capture high word, flags cover all 64 bits
            ST_EXEC_HI: begin
               rsp_result_hi <= alu_result;
               flags_p1      <= calc_flags(op_p0, alu_a[31], alu_b[31],
                                           alu_result, alu_carryout,
                                           rsp_result == '0);
               alu_a         <= '0;
               alu_b         <= '0;
               alu_binvert   <= 1'b0;
               alu_carryin   <= 1'b0;
               alu_operation <= ALU_OP_AND;
               rsp_valid     <= 1'b1;
               state         <= ST_RESP;
            end
`endif

            // ---- response: hold everything until the consumer accepts
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer with a combinational ALU model attached
// and a behavioural reference computed with plain wide arithmetic.
// Wide (two pass) scenarios are compiled in when ALU_SEQ_WIDE_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
`ifdef ALU_SEQ_WIDE_EN
   logic        cmd_wide = 1'b0;
   logic [31:0] cmd_a_hi = '0;
   logic [31:0] cmd_b_hi = '0;
   logic [31:0] rsp_result_hi;
`endif
   logic [31:0] alu_a, alu_b;
   logic        alu_binvert, alu_carryin;
   logic [1:0]  alu_operation;
   logic [31:0] alu_result;
   logic        alu_carryout;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_carry, rsp_ovf;
   logic [63:0] rsp_full;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
`ifdef ALU_SEQ_WIDE_EN
      .cmd_wide      (cmd_wide),
      .cmd_a_hi      (cmd_a_hi),
      .cmd_b_hi      (cmd_b_hi),
      .rsp_result_hi (rsp_result_hi),
`endif
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_binvert   (alu_binvert),
      .alu_carryin   (alu_carryin),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .alu_carryout  (alu_carryout),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_zero      (rsp_zero),
      .rsp_carry     (rsp_carry),
      .rsp_ovf       (rsp_ovf)
   );

`ifdef ALU_SEQ_WIDE_EN
   assign rsp_full = {rsp_result_hi, rsp_result};
`else
   assign rsp_full = {32'h0, rsp_result};
`endif

   // External ALU: CarryOut always comes from the adder, whatever Operation is.
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = {1'b0, alu_a} + {1'b0, (alu_binvert ? ~alu_b : alu_b)} + {32'h0, alu_carryin};
      case (alu_operation)
         2'b00:   alu_result = alu_a & alu_b;
         2'b01:   alu_result = alu_a | alu_b;
         2'b10:   alu_result = alu_sum[31:0];
         default: alu_result = 32'h0;
      endcase
   end
   assign alu_carryout = alu_sum[32];

   // Reference: true unsigned/signed arithmetic on 32 or 64 bit operands.
   function automatic void ref_op(input logic [1:0] op, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input bit wide,
                                  output logic [63:0] r, output logic z,
                                  output logic c, output logic v);
      logic [63:0]        a, b;
      logic [64:0]        u;
      logic signed [65:0] sa, sb, s;
      a = wide ? a_in : {32'h0, a_in[31:0]};
      b = wide ? b_in : {32'h0, b_in[31:0]};
      sa = wide ? {{2{a[63]}}, a} : {{34{a[31]}}, a[31:0]};
      sb = wide ? {{2{b[63]}}, b} : {{34{b[31]}}, b[31:0]};
      r = '0; c = 1'b0; v = 1'b0; s = '0;
      case (op)
         2'b00: r = a & b;
         2'b01: r = a | b;
         2'b10: begin
            u = {1'b0, a} + {1'b0, b};
            c = wide ? u[64] : u[32];
            r = wide ? u[63:0] : {32'h0, u[31:0]};
            s = sa + sb;
         end
         default: begin
            u = {1'b0, a} - {1'b0, b};
            c = (a >= b);
            r = wide ? u[63:0] : {32'h0, u[31:0]};
            s = sa - sb;
         end
      endcase
      if (op[1]) begin
         if (wide) v = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
         else      v = (s > 66'sh7FFF_FFFF) || (s < -66'sh8000_0000);
      end
      z = (r == 64'h0);
   endfunction

   // Present a command from IDLE, then count edges until rsp_valid (bounded).
   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
      int guard;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      total++; if (rsp_full !== 64'h0) begin bad++; $display("FAIL reset_rsp_result: got %h want 0", rsp_full); end
      total++; if ({rsp_zero, rsp_carry, rsp_ovf} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {rsp_zero, rsp_carry, rsp_ovf}); end
      total++; if ({alu_a, alu_b, alu_operation, alu_binvert, alu_carryin} !== 68'h0) begin
         bad++; $display("FAIL reset_alu: got a=%h b=%h op=%b bi=%b ci=%b want all 0", alu_a, alu_b, alu_operation, alu_binvert, alu_carryin);
      end
      reset = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, r;
      logic        z, c, v;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[5];
      int   lat;
      vecs[0] = '{2'b00, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{2'b01, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h4B4B4B4B, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{2'b10, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         total++; if (lat != 1) begin bad++; $display("FAIL dir%0d_latency: got %0d want 1", i, lat); end
         total++; if (rsp_full !== {32'h0, vecs[i].r}) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, rsp_full, vecs[i].r); end
         total++; if (rsp_zero !== vecs[i].z) begin bad++; $display("FAIL dir%0d_zero: got %b want %b", i, rsp_zero, vecs[i].z); end
         total++; if (rsp_carry !== vecs[i].c) begin bad++; $display("FAIL dir%0d_carry: got %b want %b", i, rsp_carry, vecs[i].c); end
         total++; if (rsp_ovf !== vecs[i].v) begin bad++; $display("FAIL dir%0d_ovf: got %b want %b", i, rsp_ovf, vecs[i].v); end
         release_rsp();
      end
   endtask

   task automatic test_alu_drive();
      logic [3:0] exp_ctrl[4];
      exp_ctrl[0] = 4'b0000; exp_ctrl[1] = 4'b0100; exp_ctrl[2] = 4'b1000; exp_ctrl[3] = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         cmd_op = 2'(k); cmd_a = $urandom; cmd_b = $urandom; cmd_valid = 1'b1;
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         total++; if ({alu_operation, alu_binvert, alu_carryin} !== exp_ctrl[k]) begin
            bad++; $display("FAIL drive%0d_ctrl: got %b want %b", k, {alu_operation, alu_binvert, alu_carryin}, exp_ctrl[k]);
         end
         total++; if ({alu_a, alu_b} !== {cmd_a, cmd_b}) begin bad++; $display("FAIL drive%0d_operands: got %h want %h", k, {alu_a, alu_b}, {cmd_a, cmd_b}); end
         total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL drive%0d_busy: got %b want 0", k, cmd_ready); end
         @(posedge clk); #1;
         total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL drive%0d_rsp_valid: got %b want 1", k, rsp_valid); end
         total++; if ({alu_a, alu_b, alu_operation, alu_binvert, alu_carryin} !== 68'h0) begin
            bad++; $display("FAIL drive%0d_alu_idle: got a=%h b=%h ctrl=%b want all 0", k, alu_a, alu_b, {alu_operation, alu_binvert, alu_carryin});
         end
         release_rsp();
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, ah, bh;
      logic [63:0] er;
      logic        ez, ec, ev;
      bit          w;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom; b = $urandom; ah = $urandom; bh = $urandom; w = 1'b0;
         case ($urandom_range(0, 4))
            0: begin b = a; bh = ah; end
            1: begin a = 32'h7FFFFFFF; ah = 32'h7FFFFFFF; end
            2: begin a = 32'hFFFFFFFF; b = 32'h00000001; end
            default: ;
         endcase
`ifdef ALU_SEQ_WIDE_EN
         w = bit'($urandom_range(0, 1));
         cmd_wide = w; cmd_a_hi = ah; cmd_b_hi = bh;
`endif
         ref_op(op, {ah, a}, {bh, b}, w, er, ez, ec, ev);
         issue(op, a, b, lat);
         total++; if (lat != (w ? 2 : 1)) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, (w ? 2 : 1)); end
         total++; if (rsp_full !== er) begin bad++; $display("FAIL rnd%0d_result op=%b: got %h want %h", i, op, rsp_full, er); end
         total++; if ({rsp_zero, rsp_carry, rsp_ovf} !== {ez, ec, ev}) begin
            bad++; $display("FAIL rnd%0d_flags op=%b: got %b want %b", i, op, {rsp_zero, rsp_carry, rsp_ovf}, {ez, ec, ev});
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         release_rsp();
      end
`ifdef ALU_SEQ_WIDE_EN
      cmd_wide = 1'b0;
`endif
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [66:0] snap;
      issue(2'b10, 32'd100, 32'd23, lat);
      total++; if (rsp_result !== 32'd123) begin bad++; $display("FAIL bp_result: got %h want %h", rsp_result, 32'd123); end
      snap = {rsp_full, rsp_zero, rsp_carry, rsp_ovf};
      cmd_op = 2'b11; cmd_a = 32'h1; cmd_b = 32'h2; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if ({rsp_full, rsp_zero, rsp_carry, rsp_ovf} !== snap) begin
            bad++; $display("FAIL bp_stable%0d: got %h want %h", i, {rsp_full, rsp_zero, rsp_carry, rsp_ovf}, snap);
         end
         total++; if ({rsp_valid, cmd_ready} !== 2'b10) begin bad++; $display("FAIL bp_hs%0d: got valid/ready %b want 10", i, {rsp_valid, cmd_ready}); end
      end
      cmd_valid = 1'b0;
      release_rsp();
      total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got valid/ready %b want 01", {rsp_valid, cmd_ready}); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_ignored%0d: got rsp_valid %b want 0", i, rsp_valid); end
      end
   endtask

   task automatic test_back_to_back();
      int acc, rv;
      acc = 0; rv = 0;
      cmd_op = 2'b10; cmd_a = 32'd1; cmd_b = 32'd2;
      rsp_ready = 1'b1; cmd_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready === 1'b1) acc++;
         if (rsp_valid === 1'b1) begin
            rv++;
            total++; if (rsp_result !== 32'd3) begin bad++; $display("FAIL b2b_result: got %h want 3", rsp_result); end
         end
         if (i == 29) cmd_valid = 1'b0;
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      total++; if (acc != 10) begin bad++; $display("FAIL b2b_accepts: got %0d want 10", acc); end
      total++; if (rv != 10) begin bad++; $display("FAIL b2b_responses: got %0d want 10", rv); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got cmd_ready %b want 1", cmd_ready); end
   endtask

   task automatic test_reset_mid_exec();
      int lat;
      cmd_op = 2'b10; cmd_a = 32'd5; cmd_b = 32'd6; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = 1'b1;
      #1;
      total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rst_exec_hs: got ready/valid %b want 10", {cmd_ready, rsp_valid}); end
      total++; if ({rsp_full, rsp_zero, rsp_carry, rsp_ovf} !== 67'h0) begin
         bad++; $display("FAIL rst_exec_rsp: got %h want 0", {rsp_full, rsp_zero, rsp_carry, rsp_ovf});
      end
      total++; if ({alu_a, alu_b, alu_operation, alu_binvert, alu_carryin} !== 68'h0) begin
         bad++; $display("FAIL rst_exec_alu: got a=%h b=%h ctrl=%b want all 0", alu_a, alu_b, {alu_operation, alu_binvert, alu_carryin});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp%0d: got %b want 0", i, rsp_valid); end
      end
      issue(2'b10, 32'hFFFFFFFF, 32'h00000001, lat);
      total++; if (lat != 1) begin bad++; $display("FAIL rst_after_latency: got %0d want 1", lat); end
      total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_after_result: got %h want 0", rsp_result); end
      total++; if ({rsp_zero, rsp_carry, rsp_ovf} !== 3'b110) begin bad++; $display("FAIL rst_after_flags: got %b want 110", {rsp_zero, rsp_carry, rsp_ovf}); end
      release_rsp();
   endtask

`ifdef ALU_SEQ_WIDE_EN
   task automatic test_wide();
      cmd_wide = 1'b1; cmd_op = 2'b10;
      cmd_a = 32'hFFFFFFFF; cmd_a_hi = 32'h0; cmd_b = 32'h1; cmd_b_hi = 32'h0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      total++; if ({alu_a, alu_carryin} !== {32'hFFFFFFFF, 1'b0}) begin bad++; $display("FAIL wide_lo_drive: got a=%h ci=%b want ffffffff/0", alu_a, alu_carryin); end
      @(posedge clk); #1;
      total++; if (alu_carryin !== 1'b1) begin bad++; $display("FAIL wide_hi_carryin: got %b want 1", alu_carryin); end
      total++; if ({alu_a, alu_b, alu_operation} !== {64'h0, 2'b10}) begin bad++; $display("FAIL wide_hi_drive: got a=%h b=%h op=%b", alu_a, alu_b, alu_operation); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wide_early_valid: got %b want 0", rsp_valid); end
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wide_valid: got %b want 1", rsp_valid); end
      total++; if (rsp_full !== 64'h00000001_00000000) begin bad++; $display("FAIL wide_result: got %h want 0000000100000000", rsp_full); end
      total++; if ({rsp_zero, rsp_carry, rsp_ovf} !== 3'b000) begin bad++; $display("FAIL wide_flags: got %b want 000", {rsp_zero, rsp_carry, rsp_ovf}); end
      release_rsp();
      cmd_wide = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_alu_drive();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_exec();
`ifdef ALU_SEQ_WIDE_EN
      test_wide();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
